// File: rtl/seq_signed_div_pkg.sv
// Shared types and defaults for the sequential signed divider.
package seq_signed_div_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

  // Result bundle at the default width
  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] quotient;
    logic [DEFAULT_WIDTH-1:0] remainder;
    logic                     div_zero;
    logic                     ovf;
  } div_result_t;

endpackage

// File: rtl/seq_signed_div_step.sv
// One restoring-division iteration on the combined {remainder, dividend/quotient}
// shift register: shift left, compare the upper half against the divisor,
// subtract and set the new quotient bit when it fits.
module div_step
  import seq_signed_div_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   divisor_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]   top;
  logic [WIDTH-1:0] diff;

  // Shift/compare/subtract; the carry out of the shift takes part in the compare
  always_comb begin
    top   = acc_i[2*WIDTH-1:WIDTH-1];
    // Result is below the divisor whenever it is kept, so W bits suffice
    diff  = top[WIDTH-1:0] - divisor_i;
    acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
    if (top >= {1'b0, divisor_i}) begin
      acc_o[2*WIDTH-1:WIDTH] = diff;
      acc_o[0]               = 1'b1;
    end
  end

endmodule

// File: rtl/seq_signed_div.sv
// Multi-cycle signed divider: 2W-bit dividend / W-bit divisor, restoring
// algorithm, one quotient bit per cycle, valid/ready on both sides.
// Optional embedded assertions: define SEQ_SIGNED_DIV_ASSERT_EN.
module seq_signed_div
  import seq_signed_div_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_zero,
  output logic               ovf
);

  localparam int unsigned    CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(1);
  localparam logic [WIDTH-1:0] MIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef struct packed {
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;
    logic             ovf;
  } res_t;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     dvs_mag_q, dvs_mag_d;
  logic                 q_neg_q, q_neg_d;
  logic                 r_neg_q, r_neg_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  res_t                 res_q, res_d;

  logic [2*WIDTH-1:0]   dvd_mag;
  logic [WIDTH-1:0]     dvs_mag;
  logic                 pre_dz;
  logic                 pre_ovf;
  logic [2*WIDTH-1:0]   step_acc;
  logic [WIDTH-1:0]     q_mag;
  logic [WIDTH-1:0]     r_mag;
  logic                 fix_ovf;

  // Operand magnitudes and the early-exit prechecks
  always_comb begin
    dvd_mag = dividend[2*WIDTH-1] ? -dividend : dividend;
    dvs_mag = divisor[WIDTH-1]    ? -divisor  : divisor;
    pre_dz  = (divisor == '0);
    // Quotient magnitude would need more than W bits
    pre_ovf = (dvd_mag[2*WIDTH-1:WIDTH] >= dvs_mag);
  end

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc_i    (acc_q),
    .divisor_i(dvs_mag_q),
    .acc_o    (step_acc)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = (pre_dz || pre_ovf) ? DONE : CALC;
      CALC: if (cnt_q == CNT_LAST) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; results are only visible while DONE
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    quotient  = '0;
    remainder = '0;
    div_zero  = 1'b0;
    ovf       = 1'b0;
    if (state_q == DONE) begin
      quotient  = res_q.quotient;
      remainder = res_q.remainder;
      div_zero  = res_q.div_zero;
      ovf       = res_q.ovf;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      dvs_mag_q <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      cnt_q     <= '0;
      res_q     <= '0;
    end else begin
      acc_q     <= acc_d;
      dvs_mag_q <= dvs_mag_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
    end
  end

  // Datapath next-state: capture, iterate, sign fix-up and range check
  always_comb begin
    acc_d     = acc_q;
    dvs_mag_d = dvs_mag_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    q_mag     = acc_q[WIDTH-1:0];
    r_mag     = acc_q[2*WIDTH-1:WIDTH];
    fix_ovf   = q_neg_q ? (q_mag > MIN_MAG) : q_mag[WIDTH-1];
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d     = dvd_mag;
          dvs_mag_d = dvs_mag;
          q_neg_d   = dividend[2*WIDTH-1] ^ divisor[WIDTH-1];
          r_neg_d   = dividend[2*WIDTH-1];
          cnt_d     = CNT_INIT;
          res_d     = '0;
          if (pre_dz) begin
            res_d.quotient  = '1;
            res_d.remainder = dividend[WIDTH-1:0];
            res_d.div_zero  = 1'b1;
          end else if (pre_ovf) begin
            res_d.ovf = 1'b1;
          end
        end
      end
      CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q - 1'b1;
      end
      FIX: begin
        res_d = '0;
        if (fix_ovf) begin
          res_d.ovf = 1'b1;
        end else begin
          res_d.quotient  = q_neg_q ? -q_mag : q_mag;
          res_d.remainder = r_neg_q ? -r_mag : r_mag;
        end
      end
      default: ;
    endcase
  end

`ifdef SEQ_SIGNED_DIV_ASSERT_EN
  logic                      accept;
  logic signed [2*WIDTH-1:0] chk_dvd_q;
  logic [WIDTH-1:0]          chk_dvs_q;
  logic signed [2*WIDTH-1:0] chk_q_ext, chk_r_ext, chk_d_ext;
  logic [2*WIDTH-1:0]        chk_r_abs, chk_d_abs;

  assign accept = in_valid && in_ready;

  // Keep the accepted operands for the invariant check
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_dvd_q <= '0;
      chk_dvs_q <= '0;
    end else if (accept) begin
      chk_dvd_q <= dividend;
      chk_dvs_q <= divisor;
    end
  end

  assign chk_q_ext = {{WIDTH{quotient[WIDTH-1]}}, quotient};
  assign chk_r_ext = {{WIDTH{remainder[WIDTH-1]}}, remainder};
  assign chk_d_ext = {{WIDTH{chk_dvs_q[WIDTH-1]}}, chk_dvs_q};
  assign chk_r_abs = chk_r_ext[2*WIDTH-1] ? -chk_r_ext : chk_r_ext;
  assign chk_d_abs = chk_d_ext[2*WIDTH-1] ? -chk_d_ext : chk_d_ext;

  a_invariant: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !div_zero && !ovf) |->
      ((chk_q_ext * chk_d_ext + chk_r_ext) == chk_dvd_q) && (chk_r_abs < chk_d_abs));

  a_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=>
      (out_valid && $stable(quotient) && $stable(remainder) && $stable(div_zero) && $stable(ovf)));

  a_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(in_ready && out_valid));

  a_latency: assert property (@(posedge clk) disable iff (!rst_n)
    accept |-> ((##1 out_valid) or (##1 (!out_valid) [*(WIDTH+1)] ##1 out_valid)));
`endif

endmodule

// File: doc/seq_signed_div.md
Name: seq_signed_div

Overview:
- Multi-cycle signed divider: the inverse operation of the team's combinational signed multiplier.
- Takes a 2*WIDTH-bit signed product-sized dividend and a WIDTH-bit signed divisor, and returns a WIDTH-bit quotient and remainder.
- Uses a restoring shift-subtract algorithm, one quotient bit per cycle, with a valid/ready handshake on each side.
- Serves as the formally checked counterpart of the multiplier: dividing A*B by B must return A.

Parameters:
WIDTH, 32, width of divisor, quotient and remainder; the dividend is 2*WIDTH bits

Ports:
clk  input  1  clock; all state updates on its rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
dividend  input  2*WIDTH  signed dividend
divisor  input  WIDTH  signed divisor
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
quotient  output  WIDTH  signed quotient, truncated toward zero
remainder  output  WIDTH  signed remainder; its sign follows the dividend
div_zero  output  1  divisor was zero
ovf  output  1  true quotient does not fit in WIDTH signed bits

Behaviour:
- Reset:
  - Only one clock, clk; reset rst_n is asynchronous, active-low.
  - While rst_n is low, all outputs are 0 except in_ready, which is 1. State = IDLE.
  - rst_n asserted in any state aborts the operation immediately. No partial result is ever presented.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - Accept when in_valid && in_ready; call the accept edge t.
  - Capture the operand signs and the unsigned magnitudes: |dividend| is 2W bits, so -2^(2W-1) is representable; |divisor| is W bits.
- Precheck in IDLE, at accept:
  - divisor==0: go to DONE with div_zero=1, quotient=all ones, remainder=dividend[W-1:0], ovf=0.
  - Otherwise, if |dividend|[2W-1:W] >= |divisor|: go to DONE with ovf=1, quotient=0, remainder=0.
  - Otherwise go to CALC with the iteration counter set to W.
  - In both early-exit cases out_valid is 1 in cycle t+1.
- CALC:
  - Each cycle, shift the partial remainder left by one and bring in the next dividend bit.
  - If partial remainder >= |divisor|, subtract and shift in quotient bit 1; else shift in 0.
  - Decrement the counter; on 0 go to FIX.
  - Exactly W cycles.
- FIX:
  - Negate the quotient if the operand signs differ; negate the remainder if the dividend is negative.
  - Range check: a positive quotient magnitude > 2^(W-1)-1, or a negative one > 2^(W-1), sets ovf=1 and forces quotient=0, remainder=0.
  - Then go to DONE.
  - out_valid is first 1 in cycle t+W+2.
- DONE:
  - out_valid=1, in_ready=0.
  - quotient, remainder, div_zero and ovf are held stable until out_valid && out_ready.
  - On that handshake go to IDLE; out_valid=0 and in_ready=1 in the next cycle.
  - No same-cycle output/input overlap.
  - Throughput: one operation per W+3 cycles minimum.
- Backpressure: in_valid asserted outside IDLE is ignored. Operand inputs are sampled only at accept.
- Invariant when div_zero=0 and ovf=0: quotient*divisor + remainder == dividend, and |remainder| < |divisor|.

Optional Feature:
- SEQ_SIGNED_DIV_ASSERT_EN defined: the module contains embedded concurrent assertions, each disabled while rst_n is low:
  - the invariant above whenever out_valid && !div_zero && !ovf;
  - out_valid && !out_ready implies the outputs are stable in the next cycle;
  - in_ready and out_valid are never both 1;
  - out_valid rises exactly 1 or W+2 cycles after accept.
- Not defined: no assertion code is compiled; RTL behaviour is identical.

Decomposition:
- Package seq_signed_div_pkg:
  - state enum (IDLE, CALC, FIX, DONE);
  - default WIDTH constant;
  - a result struct holding quotient, remainder, div_zero and ovf.
- One natural sub-module, div_step: the combinational single-iteration shift/compare/subtract on the 2W-bit partial remainder and the W-bit divisor, instantiated once in the CALC datapath.

Test Plan:
1. dividend=100, divisor=7 -> quotient=14, remainder=2, flags 0; out_valid first high at t+34 (W=32).
2. Signs:
   - -100/7 -> quotient=-14, remainder=-2.
   - 100/-7 -> quotient=-14, remainder=2.
   - -100/-7 -> quotient=14, remainder=-2.
3. dividend=5, divisor=0 -> div_zero=1, quotient=0xFFFFFFFF, remainder=5, out_valid at t+1.
4. Overflow cases:
   - 0x0000_0000_8000_0000 / -1 -> quotient=0x8000_0000, ovf=0.
   - The same dividend / 1 -> ovf=1 at t+34.
   - 0x8000_0000_0000_0000 / -1 -> ovf=1 at t+1.
5. 1000/3 with out_ready held 0 for 5 cycles after out_valid -> quotient=333, remainder=1 stable throughout, in_ready=0. On handshake, in_ready=1 in the next cycle; a back-to-back 9/2 then gives 4 and 1.
6. rst_n pulsed low at CALC iteration 10 -> out_valid=0 and in_ready=1 during reset. No result is emitted for the aborted operation. A following 77/11 returns 7 and 0.
